div_unit: RTL and testbench

Parametrised multi-cycle integer divider for the execute stage. It computes quotient and remainder of two WIDTH-bit operands, signed or unsigned, using radix-2 restoring division, one bit per cycle. It runs alongside the multiply-accumulate path. The execute stage holds `start_i` high and raises its stall request until `ready_o` returns. The result is written to HI/LO: remainder to HI, quotient to LO.

---
 rtl/div_unit_pkg.sv | 27 ++
 rtl/div_unit_if.sv | 22 ++
 rtl/div_unit_step.sv | 16 +
 rtl/div_unit.sv | 153 +++++++++++++++
 tb/tb_div_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the radix-2 restoring divider: FSM encodings,
// default operand width and {remainder, quotient} result field positions.
package div_unit_pkg;

    localparam int unsigned DIV_WIDTH_DEF = 32;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    // Quotient occupies the low half of the result, remainder the high half.
    localparam int unsigned QUOT_LSB = 0;

    function automatic int unsigned quot_msb(input int unsigned w);
        return w - 1;
    endfunction

    function automatic int unsigned rem_lsb(input int unsigned w);
        return w;
    endfunction

    function automatic int unsigned rem_msb(input int unsigned w);
        return 2 * w - 1;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage <-> divider request/result bundle.
interface div_unit_if #(
    parameter int unsigned WIDTH = div_unit_pkg::DIV_WIDTH_DEF
);
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit_step.sv
// One restoring-division iteration: trial subtract of the divisor from the
// shifted partial remainder.
module div_step #(
    parameter int unsigned WIDTH = div_unit_pkg::DIV_WIDTH_DEF
) (
    input  logic [WIDTH:0]   partial_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] diff_o_c,
    output logic             no_borrow_o_c
);

    // partial < 2*divisor always holds, so a successful difference fits in WIDTH bits.
    assign no_borrow_o_c = (partial_i >= {1'b0, divisor_i});
    assign diff_o_c      = partial_i[WIDTH-1:0] - divisor_i;

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned integer divider, one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN: finish at once when |dividend| < |divisor|.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEF,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);

    localparam int unsigned QUOT_MSB = quot_msb(WIDTH);
    localparam int unsigned REM_LSB  = rem_lsb(WIDTH);
    localparam int unsigned REM_MSB  = rem_msb(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               neg_quot_q, neg_quot_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic               sign_a_c, sign_b_c;
    logic [WIDTH-1:0]   mag_a_c, mag_b_c;
    logic               early_c;
    logic [WIDTH:0]     partial_c;
    logic [WIDTH-1:0]   diff_c, quot_c, rem_c;
    logic               no_borrow_c;

    // Operand magnitudes; the most-negative value maps onto its own unsigned magnitude.
    assign sign_a_c = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    assign sign_b_c = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    assign mag_a_c  = sign_a_c ? (WIDTH'(0) - bus.opdata1_i) : bus.opdata1_i;
    assign mag_b_c  = sign_b_c ? (WIDTH'(0) - bus.opdata2_i) : bus.opdata2_i;

`ifdef DIV_EARLY_OUT_EN
    assign early_c = (mag_a_c < mag_b_c);
`else
    assign early_c = 1'b0;
`endif

    // dvd_q shifts dividend bits out at the top and quotient bits in at the bottom.
    assign partial_c = {rem_q, dvd_q[WIDTH-1]};

    div_step #(.WIDTH(WIDTH)) u_step (
        .partial_i     (partial_c),
        .divisor_i     (dvs_q),
        .diff_o_c      (diff_c),
        .no_borrow_o_c (no_borrow_c)
    );

    assign quot_c = {dvd_q[WIDTH-2:0], no_borrow_c};
    assign rem_c  = no_borrow_c ? diff_c : partial_c[WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            S_IDLE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = S_BYZERO;
                    end else if (early_c) begin
                        state_d  = S_END;
                        ready_d  = 1'b1;
                        result_d = {bus.opdata1_i, WIDTH'(0)};
                    end else begin
                        state_d    = S_ON;
                        cnt_d      = '0;
                        rem_d      = '0;
                        dvd_d      = mag_a_c;
                        dvs_d      = mag_b_c;
                        neg_quot_d = sign_a_c ^ sign_b_c;
                        neg_rem_d  = sign_a_c;
                    end
                end
            end
            S_BYZERO: begin
                state_d  = S_END;
                ready_d  = 1'b1;
                result_d = '0;
            end
            S_ON: begin
                rem_d = rem_c;
                dvd_d = quot_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_END;
                    ready_d = 1'b1;
                    result_d[QUOT_MSB:QUOT_LSB] = neg_quot_q ? (WIDTH'(0) - quot_c) : quot_c;
                    result_d[REM_MSB:REM_LSB]   = neg_rem_q  ? (WIDTH'(0) - rem_c)  : rem_c;
                end
            end
            S_END: begin
                state_d = S_END;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Annul, or start withdrawn, returns to IDLE from any busy state.
        if (state_q != S_IDLE && (bus.annul_i || !bus.start_i)) begin
            state_d  = S_IDLE;
            ready_d  = 1'b0;
            result_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Randomised self-checking bench for div_unit at WIDTH 8, 16 and 32 against
// an arithmetic reference model.
module tb_div_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              start, annul, sgn;
    logic [31:0]       opa, opb;
    int unsigned       cur_w;
    logic              rdy;
    logic [31:0]       res_q, res_r;

    int n_vec = 0;
    int n_err = 0;

    div_unit_if #(.WIDTH(8))  b8();
    div_unit_if #(.WIDTH(16)) b16();
    div_unit_if #(.WIDTH(32)) b32();

    div_unit #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(b8));
    div_unit #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(b16));
    div_unit #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));

    assign b8.signed_div_i  = sgn;
    assign b8.opdata1_i     = opa[7:0];
    assign b8.opdata2_i     = opb[7:0];
    assign b8.start_i       = start && (cur_w == 8);
    assign b8.annul_i       = annul;
    assign b16.signed_div_i = sgn;
    assign b16.opdata1_i    = opa[15:0];
    assign b16.opdata2_i    = opb[15:0];
    assign b16.start_i      = start && (cur_w == 16);
    assign b16.annul_i      = annul;
    assign b32.signed_div_i = sgn;
    assign b32.opdata1_i    = opa;
    assign b32.opdata2_i    = opb;
    assign b32.start_i      = start && (cur_w == 32);
    assign b32.annul_i      = annul;

    assign rdy   = (cur_w == 8) ? b8.ready_o : (cur_w == 16) ? b16.ready_o : b32.ready_o;
    assign res_q = (cur_w == 8)  ? {24'd0, b8.result_o[7:0]} :
                   (cur_w == 16) ? {16'd0, b16.result_o[15:0]} : b32.result_o[31:0];
    assign res_r = (cur_w == 8)  ? {24'd0, b8.result_o[15:8]} :
                   (cur_w == 16) ? {16'd0, b16.result_o[31:16]} : b32.result_o[63:32];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (w=%0d sgn=%0d a=%h b=%h)",
                     tag, got, exp, cur_w, sgn, opa, opb);
        end
    endtask

    // Truncating division on sign- or zero-extended operands, wrapped to w bits.
    task automatic model(input int unsigned w, input logic s, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        logic [63:0] msk;
        msk = (64'd1 << w) - 64'd1;
        sa = longint'({32'd0, a} & msk);
        sb = longint'({32'd0, b} & msk);
        if (s) begin
            if (a[w-1]) sa = sa - (longint'(1) << w);
            if (b[w-1]) sb = sb - (longint'(1) << w);
        end
        if (sb == 0) begin
            q = '0;
            r = '0;
        end else begin
            lq = sa / sb;
            lr = sa % sb;
            q = 32'(lq & longint'(msk));
            r = 32'(lr & longint'(msk));
        end
    endtask

    // mode: 0 complete, 1 annul pulsed at cycle k, 2 start withdrawn at cycle k.
    task automatic run_op(input int unsigned w, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input int mode, input int k);
        logic [31:0] eq, er, bm;
        int lat, cyc, hold, md, kk;
        logic seen, stable;
        model(w, s, a, b, eq, er);
        bm = 32'(({32'd0, b}) & ((64'd1 << w) - 64'd1));
        if (bm == 0) lat = 2;
`ifdef DIV_EARLY_OUT_EN
        else if (eq == 0) lat = 1;
`endif
        else lat = int'(w) + 1;
        md = (lat > 1) ? mode : 0;
        kk = (k >= lat) ? lat - 1 : ((k < 1) ? 1 : k);

        cur_w = w; sgn = s; opa = a; opb = b; start = 1'b1;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < lat + 4) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                opa = $urandom;
                opb = $urandom;
                sgn = ~s;
            end
            if (rdy) begin
                seen = 1'b1;
            end else if (md != 0 && cyc == kk) begin
                if (md == 1) annul = 1'b1;
                else start = 1'b0;
                @(posedge clk); #1;
                annul = 1'b0;
                start = 1'b0;
                check("abort_ready", 64'(rdy), 64'd0);
                check("abort_result", {res_r, res_q}, 64'd0);
                return;
            end
        end
        check("latency", seen ? 64'(cyc) : 64'd0, 64'(lat));
        check("quotient", 64'(res_q), 64'(eq));
        check("remainder", 64'(res_r), 64'(er));
        hold = $urandom_range(0, 2);
        stable = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!rdy || res_q !== eq || res_r !== er) stable = 1'b0;
        end
        check("hold_stable", 64'(stable), 64'd1);
        start = 1'b0;
        @(posedge clk); #1;
        check("drop_ready", 64'(rdy), 64'd0);
        check("drop_result", {res_r, res_q}, 64'd0);
    endtask

    initial begin
        logic seen;
        int unsigned w;
        logic [31:0] a, b;
        int r, mode;

        rst = 1'b1; start = 1'b0; annul = 1'b0; sgn = 1'b0;
        opa = '0; opb = '0; cur_w = 32;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready8", 64'(b8.ready_o), 64'd0);
        check("rst_result16", 64'(b16.result_o), 64'd0);
        check("rst_ready32", 64'(b32.ready_o), 64'd0);
        check("rst_result32", b32.result_o, 64'd0);
        rst = 1'b0;

        run_op(32, 1'b0, 32'd100, 32'd7, 0, 0);
        run_op(32, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_op(32, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op(32, 1'b0, 32'h1234_5678, 32'd0, 0, 0);
        run_op(32, 1'b1, 32'h8765_4321, 32'd0, 0, 0);
        run_op(32, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 0);
        run_op(32, 1'b0, 32'd3, 32'd10, 0, 0);
        run_op(32, 1'b1, 32'd7, 32'hFFFF_FFFE, 0, 0);
        run_op(8,  1'b1, 32'h80, 32'hFF, 0, 0);
        run_op(16, 1'b1, 32'h8000, 32'd3, 0, 0);
        run_op(8,  1'b0, 32'hFF, 32'hFF, 0, 0);
        run_op(32, 1'b0, 32'd100, 32'd7, 1, 10);
        run_op(32, 1'b0, 32'd100, 32'd7, 0, 0);
        run_op(32, 1'b1, 32'hFFFF_FF00, 32'd9, 2, 5);
        run_op(16, 1'b0, 32'd500, 32'd0, 1, 1);

        // Reset in the middle of a division.
        cur_w = 32; sgn = 1'b0; opa = 32'd1000; opb = 32'd3; start = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_ready", 64'(rdy), 64'd0);
        check("midrst_result", {res_r, res_q}, 64'd0);
        rst = 1'b0; start = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (rdy) seen = 1'b1;
        end
        check("midrst_quiet", 64'(seen), 64'd0);
        run_op(32, 1'b0, 32'd1000, 32'd3, 0, 0);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 2);
            w = (r == 0) ? 8 : (r == 1) ? 16 : 32;
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 20));
            r = $urandom_range(0, 19);
            mode = (r < 3) ? 1 : (r == 3) ? 2 : 0;
            run_op(w, 1'($urandom_range(0, 1)), a, b, mode, $urandom_range(1, w));
        end

        // Nothing may surface once the last operation has been retired.
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (b8.ready_o || b16.ready_o || b32.ready_o) seen = 1'b1;
        end
        check("final_quiet", 64'(seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
